// File: rtl/div_result_formatter.sv
// ============================================================================
// Module   : div_result_formatter
// Purpose  : Captures one 4-bit divider result and streams it as an ASCII line
//            ("Q=qq R=rr\n", or "ERR\n" when the divisor is zero).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_result_formatter #(
    parameter logic [7:0] EOL_CHAR = 8'h0A,
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] quotient,
    input  logic [3:0] remainder,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic [7:0] msg_count,
    output logic [7:0] err_count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam logic [3:0] C_LAST_NORMAL = 4'd9;
    localparam logic [3:0] C_LAST_ERROR  = 4'd3;

    state_t     r_state;
    logic [3:0] r_quot;
    logic [3:0] r_rem;
    logic       r_err;
    logic [3:0] r_idx;
    logic       w_last;
    logic       w_xfer;
    logic       w_unused_a;

    // The dividend only matters upstream; it is never printed.
    assign w_unused_a = ^a;

    function automatic logic [7:0] tens_char(input logic [3:0] v);
        return (v >= 4'd10) ? 8'h31 : 8'h30;
    endfunction

    function automatic logic [7:0] ones_char(input logic [3:0] v);
        logic [3:0] o;
        o = (v >= 4'd10) ? (v - 4'd10) : v;
        return 8'h30 + {4'b0000, o};
    endfunction

    function automatic logic [7:0] fmt_byte(input logic [3:0] idx, input logic [3:0] q,
                                            input logic [3:0] r, input logic err);
        logic [7:0] c;
        c = EOL_CHAR;
        if (err) begin
            case (idx)
                4'd0:    c = 8'h45;
                4'd1:    c = 8'h52;
                4'd2:    c = 8'h52;
                default: c = EOL_CHAR;
            endcase
        end else begin
            case (idx)
                4'd0:    c = 8'h51;
                4'd1:    c = 8'h3D;
                4'd2:    c = tens_char(q);
                4'd3:    c = ones_char(q);
                4'd4:    c = SEP_CHAR;
                4'd5:    c = 8'h52;
                4'd6:    c = 8'h3D;
                4'd7:    c = tens_char(r);
                4'd8:    c = ones_char(r);
                default: c = EOL_CHAR;
            endcase
        end
        return c;
    endfunction

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_EMIT);
    assign w_xfer   = out_valid && out_ready;
    assign w_last   = r_err ? (r_idx == C_LAST_ERROR) : (r_idx == C_LAST_NORMAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_quot    <= 4'd0;
            r_rem     <= 4'd0;
            r_err     <= 1'b0;
            r_idx     <= 4'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            msg_count <= 8'd0;
            err_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state   <= S_EMIT;
                        r_quot    <= quotient;
                        r_rem     <= remainder;
                        r_err     <= (b == 4'd0);
                        r_idx     <= 4'd0;
                        // First byte comes straight from the live inputs.
                        out_data  <= fmt_byte(4'd0, quotient, remainder, (b == 4'd0));
                        out_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state   <= S_IDLE;
                            out_valid <= 1'b0;
                            if (r_err) err_count <= err_count + 8'd1;
                            else       msg_count <= msg_count + 8'd1;
                        end else begin
                            r_idx    <= r_idx + 4'd1;
                            out_data <= fmt_byte(r_idx + 4'd1, r_quot, r_rem, r_err);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_result_formatter.sv
// ============================================================================
// Module   : tb_div_result_formatter
// Purpose  : Directed self-checking bench for div_result_formatter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_result_formatter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b, quotient, remainder;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] msg_count;
    logic [7:0] err_count;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] exp_line [10];

    div_result_formatter #(.EOL_CHAR(8'h0A), .SEP_CHAR(8'h20)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .quotient  (quotient),
        .remainder (remainder),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .msg_count (msg_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Drive one result at a falling edge; it is accepted on the next rising edge.
    task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] tq,
                        input logic [3:0] tr);
        @(negedge clk);
        check("ready_before_send", {7'd0, in_ready}, 8'd1);
        a = ta; b = tb; quotient = tq; remainder = tr;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("latency1_valid", {7'd0, out_valid}, 8'd1);
        check("busy_after_accept", {7'd0, busy}, 8'd1);
    endtask

    // Collects n bytes; with toggle set, out_ready follows 1,0,0,1,0,0,...
    task automatic recv(input string tag, input int n, input bit toggle);
        int         got = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (got < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            out_ready = toggle ? ((cyc % 3) == 1) : 1'b1;
            if (stalled) begin
                check({tag, "_stall_valid"}, {7'd0, out_valid}, 8'd1);
                check({tag, "_stall_data"}, out_data, held);
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                check($sformatf("%s_byte%0d", tag, got), out_data, exp_line[got]);
                got++;
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = out_data;
            end
        end
        if (got < n) check({tag, "_timeout"}, 8'(got), 8'(n));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 4'd0; b = 4'd0; quotient = 4'd0; remainder = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_msg_count", msg_count, 8'd0);
        check("rst_err_count", err_count, 8'd0);

        // 10/3 = 3 r 1, sink always ready
        exp_line = '{8'h51, 8'h3D, 8'h30, 8'h33, 8'h20, 8'h52, 8'h3D, 8'h30, 8'h31, 8'h0A};
        send(4'd10, 4'd3, 4'd3, 4'd1);
        recv("t1", 10, 1'b0);
        check("t1_in_ready_low_before_last", {7'd0, in_ready}, 8'd0);
        @(posedge clk); #1;
        check("t1_in_ready", {7'd0, in_ready}, 8'd1);
        check("t1_out_valid", {7'd0, out_valid}, 8'd0);
        check("t1_busy", {7'd0, busy}, 8'd0);
        check("t1_msg_count", msg_count, 8'd1);

        // 15/1 = 15 r 0, sink stalling
        exp_line = '{8'h51, 8'h3D, 8'h31, 8'h35, 8'h20, 8'h52, 8'h3D, 8'h30, 8'h30, 8'h0A};
        send(4'd15, 4'd1, 4'd15, 4'd0);
        recv("t2", 10, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        check("t2_msg_count", msg_count, 8'd2);
        check("t2_out_valid", {7'd0, out_valid}, 8'd0);

        // divide by zero
        exp_line = '{8'h45, 8'h52, 8'h52, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(4'd7, 4'd0, 4'hF, 4'hF);
        recv("t3", 4, 1'b0);
        @(posedge clk); #1;
        check("t3_err_count", err_count, 8'd1);
        check("t3_msg_count", msg_count, 8'd2);
        check("t3_in_ready", {7'd0, in_ready}, 8'd1);

        // in_valid held with new operands while a line is in flight
        exp_line = '{8'h51, 8'h3D, 8'h30, 8'h32, 8'h20, 8'h52, 8'h3D, 8'h30, 8'h31, 8'h0A};
        send(4'd9, 4'd4, 4'd2, 4'd1);
        a = 4'd6; b = 4'd3; quotient = 4'd2; remainder = 4'd0;
        in_valid = 1'b1;
        recv("t4a", 10, 1'b0);
        @(posedge clk); #1;
        check("t4_idle_ready", {7'd0, in_ready}, 8'd1);
        check("t4_idle_valid", {7'd0, out_valid}, 8'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t4_second_accept", {7'd0, out_valid}, 8'd1);
        exp_line = '{8'h51, 8'h3D, 8'h30, 8'h32, 8'h20, 8'h52, 8'h3D, 8'h30, 8'h30, 8'h0A};
        recv("t4b", 10, 1'b0);
        @(posedge clk); #1;
        check("t4_msg_count", msg_count, 8'd4);

        // reset after the 4th byte of a line
        exp_line = '{8'h51, 8'h3D, 8'h31, 8'h32, 8'h20, 8'h52, 8'h3D, 8'h30, 8'h39, 8'h0A};
        send(4'd15, 4'd1, 4'd12, 4'd9);
        recv("t5a", 4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_out_valid", {7'd0, out_valid}, 8'd0);
        check("t5_in_ready", {7'd0, in_ready}, 8'd1);
        check("t5_busy", {7'd0, busy}, 8'd0);
        check("t5_msg_count", msg_count, 8'd0);
        check("t5_err_count", err_count, 8'd0);
        repeat (3) begin
            @(negedge clk);
            check("t5_no_more_bytes", {7'd0, out_valid}, 8'd0);
        end
        send(4'd15, 4'd1, 4'd12, 4'd9);
        recv("t5b", 10, 1'b0);
        @(posedge clk); #1;
        check("t5_msg_count_fresh", msg_count, 8'd1);

        // counter wrap: 255 more lines bring the total to 256
        exp_line = '{8'h51, 8'h3D, 8'h30, 8'h37, 8'h20, 8'h52, 8'h3D, 8'h30, 8'h35, 8'h0A};
        for (int i = 0; i < 255; i++) begin
            send(4'd12, 4'd1, 4'd7, 4'd5);
            recv("t6", 10, 1'b0);
            @(posedge clk); #1;
        end
        check("t6_wrap_zero", msg_count, 8'd0);
        send(4'd12, 4'd1, 4'd7, 4'd5);
        recv("t6_last", 10, 1'b0);
        @(posedge clk); #1;
        check("t6_wrap_one", msg_count, 8'd1);
        check("t6_err_count", err_count, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/div_result_formatter.md
Name: div_result_formatter

Overview:
Downstream stage of the 4-bit combinational divider. Captures one divider result (dividend, divisor, quotient, remainder) through a valid/ready handshake. Converts the result to a fixed-format ASCII line and streams it one byte per handshake to a byte sink (UART TX / log buffer). Divisor zero is detected here and replaced by an error line, since the divider itself gives no defined result for that case.

Parameters:
EOL_CHAR, 8'h0A, terminating byte of every line
SEP_CHAR, 8'h20, separator byte between quotient and remainder fields

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
a  input  4  dividend as applied to divider
b  input  4  divisor as applied to divider
quotient  input  4  divider quotient
remainder  input  4  divider remainder
in_valid  input  1  result on a/b/quotient/remainder is valid
in_ready  output  1  block can accept a result
out_data  output  8  ASCII byte
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts out_data
busy  output  1  message in progress (state != IDLE)
msg_count  output  8  completed normal lines, wraps 255->0
err_count  output  8  completed error lines, wraps 255->0

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, out_valid=0, out_data=8'h00, busy=0, msg_count=0, err_count=0, byte index=0. in_ready=1 in the first cycle after reset.
- Reset mid-message: the line is aborted, no further bytes are emitted, and counters are cleared. Reset has priority over all other events.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- IDLE -> EMIT on in_valid && in_ready:
  - register quotient, remainder, and err = (b == 4'd0); a is not stored.
  - byte index = 0.
  - out_valid=1 and the first byte on out_data in the cycle after acceptance (latency 1).
- Normal line (err=0), 10 bytes: 'Q' '=' Qt Qo SEP_CHAR 'R' '=' Rt Ro EOL_CHAR.
  - Tens digit t = (v >= 10) ? 1 : 0; ones digit o = v - 10*t.
  - Each digit is sent as 8'h30 + digit.
  - Leading zero is always printed, e.g. quotient 3 -> "03".
- Error line (err=1), 4 bytes: 'E' 'R' 'R' EOL_CHAR. quotient and remainder are ignored.
- Output handshake:
  - A byte transfers on a cycle with out_valid && out_ready.
  - Index advances by 1 per transfer.
  - While out_valid && !out_ready, out_data and out_valid hold stable (no change, no skip).
- Last-byte transfer (EOL_CHAR):
  - state -> IDLE next cycle, out_valid=0.
  - msg_count += 1 (normal) or err_count += 1 (error) in the same edge.
  - in_ready=1 the following cycle. There is no back-to-back acceptance in the same cycle as the last byte.
- Peak rate: 11 cycles per normal line, 5 per error line.
- in_valid while in EMIT is ignored: no capture. Upstream must hold until in_ready.
- Input changes on a/b/quotient/remainder during EMIT have no effect on the line in flight.
- out_data when out_valid=0: holds the last driven value; consumers must not sample it.
- Input combinations are not cross-checked: any b != 0 is formatted as given, even if quotient/remainder are inconsistent.
- Counters wrap modulo 256 with no saturation.

Test Plan:
1. a=10, b=3, q=3, r=1, in_valid pulse, out_ready=1 -> bytes 51 3D 30 33 20 52 3D 30 31 0A; first byte 1 cycle after accept; busy=0 and msg_count=1 after; in_ready high 11 cycles after accept.
2. a=15, b=1, q=15, r=0, with out_ready toggling 1,0,0,1,... -> "Q=15 R=00\n" intact; out_data stable on every stalled cycle; no byte duplicated or dropped.
3. b=0 (q/r arbitrary, e.g. 4'hF) -> bytes 45 52 52 0A; err_count=1, msg_count unchanged.
4. in_valid held high with new operands (a=9,b=4,q=2,r=1 then a=6,b=3,q=2,r=0) during EMIT -> first line "Q=02 R=01\n" unaffected; second captured only when in_ready=1; second line "Q=02 R=00\n".
5. rst asserted after 4th byte of a normal line -> next cycle out_valid=0, in_ready=1, counters=0; no further bytes of that line; a fresh result then formats correctly.
6. 256 consecutive normal results -> msg_count wraps to 0; 257th result -> msg_count=1.
